rr_sequencer: RTL and testbench
===============================

# rr_sequencer

Parametrised hardwired control sequencer for register-register ALU instructions. It generates every datapath control strobe that the T0–T6 fetch/execute steps require, so those strobes no longer come from hand-driven bench stimulus. It sits beside `datapath` and drives its register-select, bus-out, load-enable and ALU-opcode inputs. It adds four things:

- memory wait states;
- HI/LO writeback for multiply/divide;
- illegal-instruction fault detection;
- continuous run mode.

## Interface
Parameters:
- `NREG`, 16: number of general registers (widths of `Rin` and `Rout`); legal range 2–16.
- `DATA_W`, 32: IR width.
- `OPC_W`, 5: opcode width, IR[DATA_W-1 -: OPC_W].
- `FLD_W`, 4: register-field width; ra, rb and rc follow the opcode, msb first.

Ports:
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Clear_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin an instruction; sampled only in IDLE.
- `run`  in  1  1 = chain straight into the next fetch after completion.
- `mem_ready`  in  1  memory data valid; sampled in T1.
- `ir`  in  DATA_W  current IR contents from the datapath.
- `PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, HIin, LOin`  out  1 each  datapath strobes.
- `Rin, Rout`  out  NREG  one-hot register load and drive selects.
- `alu_op`  out  OPC_W  ALU operation; drives the datapath opcode input.
- `busy`  out  1  high in any state other than IDLE and FAULT.
- `done`  out  1  one-cycle pulse in the final step of each instruction.
- `fault`  out  1  high in FAULT.

## Operation
Every output is a Moore function of state and `ir`. Reset value of every output is 0, and the state resets to IDLE.

States and actions:
- IDLE: all strobes 0. If `start`, go to T0.
- T0: assert PCout, MARin, IncPC, Zin. Go to T1.
- T1: assert Zlowout, PCin, Read, MDRin. Stay in T1 while `mem_ready` is 0; go to T2 when it is 1.
  - PCin is asserted only on the first T1 cycle, so PC increments exactly once regardless of wait states.
- T2: assert MDRout, IRin. Go to T3.
- T3: decode `ir`.
  - If the opcode is illegal, or any used register field is ≥ NREG, go to FAULT with no strobes asserted.
  - Otherwise assert Rout[rb] and Yin, then go to T4.
- T4: assert Rout[rc], Zin, and `alu_op` = opcode. Go to T5.
- T5:
  - Normal op: assert Zlowout and Rin[ra], pulse `done`, then go to T0 if `run`, else IDLE.
  - MUL/DIV: assert Zlowout and LOin, then go to T6.
- T6 (MUL/DIV only): assert Zhighout and HIin, pulse `done`, then go to T0 if `run`, else IDLE.
- FAULT: all strobes 0. Held until `Clear_n` is asserted; `start` is ignored.

Rules:
- `alu_op` is 0 in every state except T4.
- `Rin` and `Rout` are zero or one-hot in all states.
- `ir` must be stable from T3 to the end of the instruction. The IR register updates on the edge that leaves T2.
- For MUL/DIV the ra field is ignored and not range-checked.
- `start` while busy is ignored.
- `Clear_n` low mid-instruction zeroes all outputs asynchronously and forces IDLE; no partial writeback strobe is completed.

## Timing
Latency from the `start`-sampling edge, with no wait states:
- Normal op: T0..T5, 6 cycles.
- MUL/DIV: 7 cycles.
- Each cycle `mem_ready` is low in T1 adds one cycle.

Handshake and sequencing:
- Read/MDRin stay high for the entire T1 dwell, including wait cycles.
- `done` is coincident with the writeback strobe.
- With `run` = 1, T0 of the next instruction immediately follows the `done` cycle, with zero bubble.

## Structure
Package `rr_pkg` holds:
- the state enum;
- opcode constants: OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110, OP_MUL = 5'b01111, OP_DIV = 5'b10000;
- the legal-range rule: 00011–10000 is legal, everything else is illegal.

One sub-module, `ir_decode`, is combinational. It extracts opcode, ra, rb and rc, and produces the `is_muldiv` and `illegal` flags.

## Test plan
- `ir` = 0x28918000 (AND, ra = 1, rb = 2, rc = 3), `mem_ready` = 1, `run` = 0, `start` pulse. Required:
  - T3: Rout = 0x0004 with Yin.
  - T4: Rout = 0x0008, `alu_op` = 5'b00101, Zin.
  - T5: Rin = 0x0002, Zlowout, `done`.
  - Back in IDLE 6 cycles after start.
- `ir` = 0x78918000 (MUL, rb = 2, rc = 3). Required:
  - T5: LOin with Zlowout.
  - T6: HIin with Zhighout and `done`.
  - Rin stays 0 throughout; 7 cycles total.
- `mem_ready` held low for 3 T1 cycles. Required: Read/MDRin high for 4 cycles, PCin high for 1 cycle, total 9 cycles for the AND instruction.
- Fault cases: `ir` = 0xF8918000 (opcode 11111), and separately NREG = 8 with rb = 9. Required: FAULT entered after T3, Rin/Rout never nonzero in T3 or later, `fault` = 1, `start` ignored until `Clear_n` is asserted.
- Two AND instructions with `run` = 1. Required: T0 follows the first `done` cycle directly and 2 `done` pulses in 12 cycles. Then `Clear_n` pulsed during T4 of the second instruction: all outputs 0 immediately, then IDLE.

Source files
------------

// File: rtl/rr_pkg.sv
// ----------------------------------------------------------------------------
// rr_pkg
// Shared definitions for the register-register instruction sequencer:
//   - rr_state_e : sequencer state encoding (IDLE, T0..T6, FAULT plus the
//                  T1 memory-wait dwell state)
//   - OP_*       : ALU opcode constants
//   - opc_legal  : legal opcode range rule (OP_ADD..OP_DIV inclusive)
// ----------------------------------------------------------------------------
package rr_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,     // first T1 cycle: PC load happens here only
      S_T1W,    // T1 repeated while memory is not ready
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_FAULT
   } rr_state_e;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   // Opcodes from OP_ADD up to OP_DIV are implemented; everything else traps.
   function automatic logic opc_legal(input logic [31:0] opc);
      return (opc >= 32'(OP_ADD)) && (opc <= 32'(OP_DIV));
   endfunction

endpackage

// File: rtl/rr_sequencer_if.sv
// ----------------------------------------------------------------------------
// rr_sequencer_if
// Bundle between the sequencer and its environment.
//   Inputs to the sequencer : start, run, mem_ready, ir
//   Datapath strobes        : PCout MARin IncPC Zin PCin Read MDRin MDRout IRin
//                             Yin Zlowout Zhighout HIin LOin, Rin/Rout (one-hot),
//                             alu_op
//   Status                  : busy, done, fault
// Modports: slave = the sequencer, master = the controller/bench driving it.
// ----------------------------------------------------------------------------
interface rr_sequencer_if #(
   parameter int NREG   = 16,
   parameter int DATA_W = 32,
   parameter int OPC_W  = 5
);
   logic              start;
   logic              run;
   logic              mem_ready;
   logic [DATA_W-1:0] ir;

   logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin;
   logic Yin, Zlowout, Zhighout, HIin, LOin;
   logic [NREG-1:0]   Rin;
   logic [NREG-1:0]   Rout;
   logic [OPC_W-1:0]  alu_op;
   logic              busy;
   logic              done;
   logic              fault;

   modport slave (
      input  start, run, mem_ready, ir,
      output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin,
             Yin, Zlowout, Zhighout, HIin, LOin, Rin, Rout, alu_op,
             busy, done, fault
   );

   modport master (
      output start, run, mem_ready, ir,
      input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin,
             Yin, Zlowout, Zhighout, HIin, LOin, Rin, Rout, alu_op,
             busy, done, fault
   );
endinterface

// File: rtl/ir_decode.sv
// ----------------------------------------------------------------------------
// ir_decode
// Combinational instruction decode.
//   ir        in  : instruction register contents
//   opc       out : IR[DATA_W-1 -: OPC_W]
//   ra/rb/rc  out : register fields following the opcode, msb first
//   is_muldiv out : opcode is MUL or DIV (HI/LO writeback)
//   illegal   out : opcode outside the legal range, or a used register
//                   field >= NREG (ra is unused by MUL/DIV)
// ----------------------------------------------------------------------------
module ir_decode
   import rr_pkg::*;
#(
   parameter int NREG   = 16,
   parameter int DATA_W = 32,
   parameter int OPC_W  = 5,
   parameter int FLD_W  = 4
) (
   input  logic [DATA_W-1:0] ir,
   output logic [OPC_W-1:0]  opc,
   output logic [FLD_W-1:0]  ra,
   output logic [FLD_W-1:0]  rb,
   output logic [FLD_W-1:0]  rc,
   output logic              is_muldiv,
   output logic              illegal
);
   localparam int              LOW_W  = DATA_W - OPC_W - 3*FLD_W;
   // One extra bit so NREG = 2**FLD_W is representable.
   localparam logic [FLD_W:0]  NREG_L = (FLD_W+1)'(NREG);

   logic unused_low;

   assign opc = ir[DATA_W-1 -: OPC_W];
   assign ra  = ir[DATA_W-OPC_W-1 -: FLD_W];
   assign rb  = ir[DATA_W-OPC_W-FLD_W-1 -: FLD_W];
   assign rc  = ir[DATA_W-OPC_W-2*FLD_W-1 -: FLD_W];

   assign unused_low = ^ir[LOW_W-1:0];

   assign is_muldiv = (32'(opc) == 32'(OP_MUL)) || (32'(opc) == 32'(OP_DIV));

   assign illegal = !opc_legal(32'(opc))
                 || ({1'b0, rb} >= NREG_L)
                 || ({1'b0, rc} >= NREG_L)
                 || (!is_muldiv && ({1'b0, ra} >= NREG_L));
endmodule

// File: rtl/rr_sequencer.sv
// ----------------------------------------------------------------------------
// rr_sequencer
// Hardwired T0..T6 control sequencer for register-register ALU instructions.
//   Clock    in : rising-edge clock
//   Clear_n  in : asynchronous active-low reset (forces IDLE, outputs 0)
//   bus         : rr_sequencer_if.slave - start/run/mem_ready/ir in,
//                 datapath strobes, Rin/Rout, alu_op, busy/done/fault out
// All outputs are Moore functions of the state and the decoded ir.
// ----------------------------------------------------------------------------
module rr_sequencer
   import rr_pkg::*;
#(
   parameter int NREG   = 16,
   parameter int DATA_W = 32,
   parameter int OPC_W  = 5,
   parameter int FLD_W  = 4
) (
   input  logic            Clock,
   input  logic            Clear_n,
   rr_sequencer_if.slave   bus
);
   localparam logic [NREG-1:0] ONE = NREG'(1);

   rr_state_e         state, state_nxt;
   logic [OPC_W-1:0]  opc;
   logic [FLD_W-1:0]  ra, rb, rc;
   logic              is_muldiv;
   logic              illegal;

   ir_decode #(
      .NREG   (NREG),
      .DATA_W (DATA_W),
      .OPC_W  (OPC_W),
      .FLD_W  (FLD_W)
   ) u_decode (
      .ir        (bus.ir),
      .opc       (opc),
      .ra        (ra),
      .rb        (rb),
      .rc        (rc),
      .is_muldiv (is_muldiv),
      .illegal   (illegal)
   );

   always_ff @(posedge Clock or negedge Clear_n) begin
      if (!Clear_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bus.PCout    = 1'b0;
      bus.MARin    = 1'b0;
      bus.IncPC    = 1'b0;
      bus.Zin      = 1'b0;
      bus.PCin     = 1'b0;
      bus.Read     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.Rin      = '0;
      bus.Rout     = '0;
      bus.alu_op   = '0;
      bus.done     = 1'b0;
      bus.fault    = 1'b0;
      bus.busy     = (state != S_IDLE) && (state != S_FAULT);

      unique case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_T0;
         end
         S_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
            state_nxt = S_T1;
         end
         S_T1, S_T1W: begin
            // Read/MDRin hold through wait cycles; PC loads only once.
            bus.Zlowout = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            bus.PCin    = (state == S_T1);
            state_nxt   = bus.mem_ready ? S_T2 : S_T1W;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_nxt  = S_T3;
         end
         S_T3: begin
            if (illegal) begin
               state_nxt = S_FAULT;
            end else begin
               bus.Rout  = ONE << rb;
               bus.Yin   = 1'b1;
               state_nxt = S_T4;
            end
         end
         S_T4: begin
            bus.Rout   = ONE << rc;
            bus.Zin    = 1'b1;
            bus.alu_op = opc;
            state_nxt  = S_T5;
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (is_muldiv) begin
               bus.LOin  = 1'b1;
               state_nxt = S_T6;
            end else begin
               bus.Rin   = ONE << ra;
               bus.done  = 1'b1;
               state_nxt = bus.run ? S_T0 : S_IDLE;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            bus.done     = 1'b1;
            state_nxt    = bus.run ? S_T0 : S_IDLE;
         end
         S_FAULT: begin
            bus.fault = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_rr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rr_sequencer
// Directed and randomized checks of rr_sequencer (NREG = 16 and NREG = 8
// instances). A per-instruction expected trace is built from the instruction
// fields and the number of memory wait cycles, then compared cycle by cycle.
// ----------------------------------------------------------------------------
module tb_rr_sequencer;

   localparam logic [13:0] PCOUT  = 14'h2000, MARIN = 14'h1000, INCPC = 14'h0800,
                           ZIN    = 14'h0400, PCIN  = 14'h0200, READ  = 14'h0100,
                           MDRIN  = 14'h0080, MDROUT = 14'h0040, IRIN = 14'h0020,
                           YIN    = 14'h0010, ZLO   = 14'h0008, ZHI   = 14'h0004,
                           HIIN   = 14'h0002, LOIN  = 14'h0001;

   logic        Clock = 1'b0;
   logic        Clear_n = 1'b0;
   logic        start16 = 1'b0;
   logic        start8 = 1'b0;
   logic        run = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] ir = '0;

   int tests = 0;
   int fails = 0;

   logic [53:0] exp_q[$];
   bit          mr_q[$];
   bit          exp_legal;

   always #5 Clock = ~Clock;

   rr_sequencer_if #(.NREG(16), .DATA_W(32), .OPC_W(5)) b16 ();
   rr_sequencer_if #(.NREG(8),  .DATA_W(32), .OPC_W(5)) b8 ();

   assign b16.start = start16;  assign b8.start = start8;
   assign b16.run = run;        assign b8.run = run;
   assign b16.mem_ready = mem_ready;  assign b8.mem_ready = mem_ready;
   assign b16.ir = ir;          assign b8.ir = ir;

   rr_sequencer #(.NREG(16), .DATA_W(32), .OPC_W(5), .FLD_W(4)) u16 (
      .Clock(Clock), .Clear_n(Clear_n), .bus(b16.slave));
   rr_sequencer #(.NREG(8), .DATA_W(32), .OPC_W(5), .FLD_W(4)) u8 (
      .Clock(Clock), .Clear_n(Clear_n), .bus(b8.slave));

   logic [53:0] obs16, obs8;
   assign obs16 = {b16.PCout, b16.MARin, b16.IncPC, b16.Zin, b16.PCin, b16.Read,
                   b16.MDRin, b16.MDRout, b16.IRin, b16.Yin, b16.Zlowout,
                   b16.Zhighout, b16.HIin, b16.LOin, b16.busy, b16.done, b16.fault,
                   b16.Rin, b16.Rout, b16.alu_op};
   assign obs8  = {b8.PCout, b8.MARin, b8.IncPC, b8.Zin, b8.PCin, b8.Read,
                   b8.MDRin, b8.MDRout, b8.IRin, b8.Yin, b8.Zlowout,
                   b8.Zhighout, b8.HIin, b8.LOin, b8.busy, b8.done, b8.fault,
                   8'h00, b8.Rin, 8'h00, b8.Rout, b8.alu_op};

   function automatic logic [53:0] ev(input logic [13:0] s, input bit bsy,
                                      input bit dn, input bit flt,
                                      input logic [15:0] rin, input logic [15:0] rout,
                                      input logic [4:0] alu);
      return {s, bsy, dn, flt, rin, rout, alu};
   endfunction

   function automatic logic [53:0] cur(input int nreg);
      return (nreg == 8) ? obs8 : obs16;
   endfunction

   task automatic check(input string tag, input logic [53:0] o, input logic [53:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // Expected per-cycle outputs from T0 to the last step of the instruction.
   task automatic build_trace(input logic [31:0] iv, input int nreg, input int waits);
      int opc, ra, rb, rc;
      bit md;
      opc = int'(iv[31:27]);
      ra  = int'(iv[26:23]);
      rb  = int'(iv[22:19]);
      rc  = int'(iv[18:15]);
      md  = (opc == 15) || (opc == 16);
      exp_legal = (opc >= 3) && (opc <= 16) && (rb < nreg) && (rc < nreg) &&
                  (md || ra < nreg);
      exp_q.delete();
      mr_q.delete();
      exp_q.push_back(ev(PCOUT | MARIN | INCPC | ZIN, 1, 0, 0, 0, 0, 0));
      mr_q.push_back(1'($urandom_range(0, 1)));
      for (int w = 0; w <= waits; w++) begin
         exp_q.push_back(ev(ZLO | READ | MDRIN | ((w == 0) ? PCIN : 14'h0), 1, 0, 0, 0, 0, 0));
         mr_q.push_back(w == waits);
      end
      exp_q.push_back(ev(MDROUT | IRIN, 1, 0, 0, 0, 0, 0));
      mr_q.push_back(1'($urandom_range(0, 1)));
      if (!exp_legal) begin
         exp_q.push_back(ev(14'h0, 1, 0, 0, 0, 0, 0));
         mr_q.push_back(1'b0);
         return;
      end
      exp_q.push_back(ev(YIN, 1, 0, 0, 0, 16'h1 << rb, 0));
      exp_q.push_back(ev(ZIN, 1, 0, 0, 0, 16'h1 << rc, 5'(opc)));
      if (md) begin
         exp_q.push_back(ev(ZLO | LOIN, 1, 0, 0, 0, 0, 0));
         exp_q.push_back(ev(ZHI | HIIN, 1, 1, 0, 0, 0, 0));
         mr_q.push_back(1'b0);
         mr_q.push_back(1'b1);
      end else begin
         exp_q.push_back(ev(ZLO, 1, 1, 0, 16'h1 << ra, 0, 0));
      end
      mr_q.push_back(1'b0);
      mr_q.push_back(1'b1);
   endtask

   task automatic apply_clear(input int nreg, input string tag);
      Clear_n = 1'b0;
      #1;
      check({tag, "_clr"}, cur(nreg), '0);
      @(negedge Clock);
      Clear_n = 1'b1;
      @(posedge Clock); #1;
      check({tag, "_idle"}, cur(nreg), '0);
   endtask

   // Runs one instruction. from_idle=0 means the DUT is already in T0 (run chain).
   // abort_at >= 0 pulls Clear_n low in that trace step instead of finishing.
   task automatic run_instr(input logic [31:0] iv, input int nreg, input int waits,
                            input bit run_v, input bit from_idle, input int abort_at,
                            input string tag);
      ir  = iv;
      run = run_v;
      build_trace(iv, nreg, waits);
      if (from_idle) begin
         if (nreg == 8) start8 = 1'b1; else start16 = 1'b1;
         @(posedge Clock); #1;
         start8 = 1'b0;
         start16 = 1'b0;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s[%0d]", tag, i), cur(nreg), exp_q[i]);
         if (i == abort_at) begin
            apply_clear(nreg, tag);
            return;
         end
         mem_ready = mr_q[i];
         @(posedge Clock); #1;
      end
      if (!exp_legal) begin
         check({tag, "_fault"}, cur(nreg), ev(14'h0, 0, 0, 1, 0, 0, 0));
         if (nreg == 8) start8 = 1'b1; else start16 = 1'b1;
         repeat (2) begin
            @(posedge Clock); #1;
            check({tag, "_fault_hold"}, cur(nreg), ev(14'h0, 0, 0, 1, 0, 0, 0));
         end
         start8 = 1'b0;
         start16 = 1'b0;
         apply_clear(nreg, tag);
      end else if (!run_v) begin
         check({tag, "_end_idle"}, cur(nreg), '0);
      end
   endtask

   initial begin
      logic [31:0] iv;
      logic [4:0]  op;
      bit          prev_run;
      logic [4:0]  legal_ops [6];
      legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111, 5'b10000};

      repeat (2) @(posedge Clock);
      #1;
      check("rst16", obs16, '0);
      check("rst8", obs8, '0);
      @(negedge Clock);
      Clear_n = 1'b1;
      @(posedge Clock); #1;
      check("idle16", obs16, '0);

      run_instr(32'h28918000, 16, 0, 0, 1, -1, "and");
      run_instr(32'h78918000, 16, 0, 0, 1, -1, "mul");
      run_instr(32'h28918000, 16, 3, 0, 1, -1, "and_wait3");
      run_instr({5'b10000, 4'd15, 4'd0, 4'd15, 15'd0}, 16, 1, 0, 1, -1, "div_edge");
      run_instr({5'b00011, 4'd0, 4'd15, 4'd0, 15'd0}, 16, 0, 0, 1, -1, "add_edge");
      run_instr(32'hF8918000, 16, 0, 0, 1, -1, "ill_11111");
      run_instr({5'b00010, 4'd1, 4'd2, 4'd3, 15'd0}, 16, 0, 0, 1, -1, "ill_00010");
      run_instr({5'b10001, 4'd1, 4'd2, 4'd3, 15'd0}, 16, 2, 0, 1, -1, "ill_10001");

      run_instr({5'b00101, 4'd1, 4'd9, 4'd3, 15'd0}, 8, 0, 0, 1, -1, "n8_rb9");
      run_instr({5'b00101, 4'd8, 4'd2, 4'd3, 15'd0}, 8, 0, 0, 1, -1, "n8_ra8");
      run_instr({5'b00110, 4'd7, 4'd2, 4'd6, 15'd0}, 8, 1, 0, 1, -1, "n8_or");
      run_instr({5'b01111, 4'd12, 4'd2, 4'd6, 15'd0}, 8, 0, 0, 1, -1, "n8_mul_ra");

      run_instr(32'h28918000, 16, 0, 1, 1, -1, "run_a");
      run_instr(32'h28918000, 16, 0, 0, 0, -1, "run_b");
      run_instr(32'h28918000, 16, 0, 1, 1, -1, "abort_a");
      run_instr(32'h28918000, 16, 0, 0, 0, 4, "abort_b");

      prev_run = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) op = 5'($urandom);
         else op = legal_ops[$urandom_range(0, 5)];
         iv = {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
         run_instr(iv, 16, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   !prev_run, -1, $sformatf("rnd%0d", n));
         prev_run = exp_legal && run;
      end
      if (prev_run) run_instr(32'h30918000, 16, 0, 0, 0, -1, "rnd_tail");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
